// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: core-side FPU port initiator that issues one decoded FP instruction at a time,
// returns its result and flags, and owns the architectural frm and sticky fflags state.
//
// Ports:
//   clk, n_rst                  clock (rising edge), asynchronous active-low reset
//   req_*                       decoded instruction from the pipeline (valid/ready handshake)
//   resp_*                      result, per-op flags, illegal-rm and timeout status (valid/ready)
//   fcsr_frm_wr/_wdata          write of frm
//   fcsr_fflags_clr             clear of sticky fflags
//   fcsr_frm, fcsr_fflags       architectural rounding mode and sticky flags
//   f_rs1/f_rs2/f_rd, frm_in,
//   f_funct_7, f_LW, f_SW,
//   dload_ext                   FPU command, non-zero only while waiting on the FPU
//   FPU_all_out, f_flags,
//   f_ready, f_frm_out          FPU response (f_frm_out unused)
//
// Optional feature: define FPU_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES cycles.
module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_funct_7,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [4:0]  req_rd,
   input  logic [2:0]  req_rm,
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic [31:0] req_load_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_flags,
   output logic        resp_illegal,
   output logic        resp_timeout,
   input  logic        fcsr_frm_wr,
   input  logic [2:0]  fcsr_frm_wdata,
   input  logic        fcsr_fflags_clr,
   output logic [2:0]  fcsr_frm,
   output logic [4:0]  fcsr_fflags,
   output logic [4:0]  f_rs1,
   output logic [4:0]  f_rs2,
   output logic [4:0]  f_rd,
   output logic [2:0]  frm_in,
   output logic [7:0]  f_funct_7,
   output logic        f_LW,
   output logic        f_SW,
   output logic [31:0] dload_ext,
   input  logic [31:0] FPU_all_out,
   input  logic [4:0]  f_flags,
   input  logic        f_ready,
   input  logic [2:0]  f_frm_out
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [7:0]  c_funct_7;
   logic [4:0]  c_rs1, c_rs2, c_rd;
   logic [2:0]  c_rm;
   logic        c_ld, c_st;
   logic [31:0] c_data;
   logic [2:0]  eff_rm;
   logic        rm_bad, wait_st, accept, arith_cap, tmo;
   logic        unused;
   assign unused = ^{f_frm_out, TIMEOUT_CYCLES[0]};
   // Dynamic rm resolves against the registered frm, so a same-cycle frm write is not seen.
   assign eff_rm    = (req_rm == 3'b111) ? fcsr_frm : req_rm;
   assign rm_bad    = eff_rm >= 3'b101;
   assign wait_st   = state == WAIT;
   assign accept    = (state == IDLE) && req_valid;
   assign arith_cap = wait_st && f_ready && !c_ld && !c_st;
`ifdef FPU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   // Held at zero outside WAIT, so it is already clear on WAIT entry.
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) cnt <= '0;
      else if (!wait_st) cnt <= '0;
      else if (!f_ready) cnt <= cnt + 1'b1;
   // Fires in the cycle the count would reach the limit; f_ready in that cycle takes priority.
   assign tmo = wait_st && !f_ready && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = req_valid ? (rm_bad ? RESP : WAIT) : IDLE;
         WAIT:    state_nxt = (f_ready || tmo) ? RESP : WAIT;
         RESP:    state_nxt = resp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         c_funct_7    <= '0;
         c_rs1        <= '0;
         c_rs2        <= '0;
         c_rd         <= '0;
         c_rm         <= '0;
         c_ld         <= 1'b0;
         c_st         <= 1'b0;
         c_data       <= '0;
         resp_data    <= '0;
         resp_flags   <= '0;
         resp_illegal <= 1'b0;
         resp_timeout <= 1'b0;
         fcsr_frm     <= '0;
         fcsr_fflags  <= '0;
      end else begin
         if (accept) begin
            c_funct_7    <= req_funct_7;
            c_rs1        <= req_rs1;
            c_rs2        <= req_rs2;
            c_rd         <= req_rd;
            c_rm         <= eff_rm;
            c_ld         <= req_is_load;
            c_st         <= req_is_store;
            c_data       <= req_load_data;
            resp_data    <= '0;
            resp_flags   <= '0;
            resp_illegal <= rm_bad;
            resp_timeout <= 1'b0;
         end
         if (wait_st && f_ready) begin
            resp_data  <= FPU_all_out;
            resp_flags <= (c_ld || c_st) ? 5'b0 : f_flags;
         end else if (tmo) resp_timeout <= 1'b1;
         if (fcsr_frm_wr) fcsr_frm <= fcsr_frm_wdata;
         fcsr_fflags <= (fcsr_fflags_clr ? 5'b0 : fcsr_fflags) | (arith_cap ? f_flags : 5'b0);
      end
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign f_funct_7  = wait_st ? c_funct_7 : 8'h00;
   assign f_rs1      = wait_st ? c_rs1 : 5'b0;
   assign f_rs2      = wait_st ? c_rs2 : 5'b0;
   assign f_rd       = wait_st ? c_rd : 5'b0;
   assign frm_in     = wait_st ? c_rm : 3'b0;
   assign f_LW       = wait_st && c_ld;
   assign f_SW       = wait_st && c_st;
   assign dload_ext  = wait_st ? c_data : 32'h0;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed and randomized checks of fpu_issue_ctrl against a behavioural model.
module tb_fpu_issue_ctrl;
   localparam int TO = 64;
   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        req_valid = 0, req_ready, req_is_load = 0, req_is_store = 0;
   logic [7:0]  req_funct_7 = 0;
   logic [4:0]  req_rs1 = 0, req_rs2 = 0, req_rd = 0;
   logic [2:0]  req_rm = 0;
   logic [31:0] req_load_data = 0;
   logic        resp_valid, resp_ready = 0, resp_illegal, resp_timeout;
   logic [31:0] resp_data;
   logic [4:0]  resp_flags;
   logic        fcsr_frm_wr = 0, fcsr_fflags_clr = 0;
   logic [2:0]  fcsr_frm_wdata = 0, fcsr_frm;
   logic [4:0]  fcsr_fflags;
   logic [4:0]  f_rs1, f_rs2, f_rd;
   logic [2:0]  frm_in;
   logic [7:0]  f_funct_7;
   logic        f_LW, f_SW;
   logic [31:0] dload_ext;
   logic [31:0] FPU_all_out = 0;
   logic [4:0]  f_flags = 0;
   logic        f_ready = 0;
   logic [2:0]  f_frm_out = 0;
   int          n_tests = 0, n_fail = 0;
   logic [2:0]  m_frm = 0;
   logic [4:0]  m_fflags = 0;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_funct_7(req_funct_7), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .req_rm(req_rm), .req_is_load(req_is_load), .req_is_store(req_is_store),
      .req_load_data(req_load_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_flags(resp_flags), .resp_illegal(resp_illegal),
      .resp_timeout(resp_timeout), .fcsr_frm_wr(fcsr_frm_wr), .fcsr_frm_wdata(fcsr_frm_wdata),
      .fcsr_fflags_clr(fcsr_fflags_clr), .fcsr_frm(fcsr_frm), .fcsr_fflags(fcsr_fflags),
      .f_rs1(f_rs1), .f_rs2(f_rs2), .f_rd(f_rd), .frm_in(frm_in), .f_funct_7(f_funct_7),
      .f_LW(f_LW), .f_SW(f_SW), .dload_ext(dload_ext), .FPU_all_out(FPU_all_out),
      .f_flags(f_flags), .f_ready(f_ready), .f_frm_out(f_frm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_frm(input logic [2:0] v);
      fcsr_frm_wr = 1'b1;
      fcsr_frm_wdata = v;
      tick;
      fcsr_frm_wr = 1'b0;
      m_frm = v;
      chk("frm_write", 32'(fcsr_frm), 32'(m_frm));
   endtask

   task automatic clr_flags;
      fcsr_fflags_clr = 1'b1;
      tick;
      fcsr_fflags_clr = 1'b0;
      m_fflags = 5'b0;
      chk("fflags_clr", 32'(fcsr_fflags), 32'(m_fflags));
   endtask

   // One full transaction: accept, lat WAIT cycles (f_ready in the last), hold RESP, handshake.
   task automatic op(input logic [7:0] f7, input logic [2:0] rm, input logic ld, input logic st,
                     input logic [31:0] ld_data, input int lat, input logic [31:0] res,
                     input logic [4:0] fl, input int hold, input logic clr_rdy,
                     input logic wr_acc, input logic [2:0] wr_val);
      logic [2:0]  eff;
      logic        bad;
      logic [4:0]  ef, a, b, d;
      logic [31:0] exp_data;
      a = 5'($urandom);
      b = 5'($urandom);
      d = 5'($urandom);
      eff = (rm == 3'b111) ? m_frm : rm;
      bad = eff >= 3'd5;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_funct_7 = f7;
      req_rs1 = a;
      req_rs2 = b;
      req_rd = d;
      req_rm = rm;
      req_is_load = ld;
      req_is_store = st;
      req_load_data = ld_data;
      fcsr_frm_wr = wr_acc;
      fcsr_frm_wdata = wr_val;
      tick;
      if (wr_acc) m_frm = wr_val;
      req_valid = 1'b0;
      req_funct_7 = 8'($urandom);
      req_rs1 = 5'($urandom);
      req_rm = 3'($urandom);
      req_is_load = 1'b0;
      req_is_store = 1'b0;
      req_load_data = $urandom;
      fcsr_frm_wr = 1'b0;
      if (bad) begin
         exp_data = 32'h0;
         ef = 5'b0;
         chk("ill_resp_valid", 32'(resp_valid), 32'd1);
         chk("ill_flag", 32'(resp_illegal), 32'd1);
         chk("ill_data", resp_data, 32'h0);
         chk("ill_flags", 32'(resp_flags), 32'h0);
         chk("ill_funct7", 32'(f_funct_7), 32'h0);
      end else begin
         for (int i = 0; i < lat; i++) begin
            chk("wait_funct7", 32'(f_funct_7), 32'(f7));
            chk("wait_frm_in", 32'(frm_in), 32'(eff));
            chk("wait_regs", 32'({f_rs1, f_rs2, f_rd}), 32'({a, b, d}));
            chk("wait_lw_sw", 32'({f_LW, f_SW}), 32'({ld, st}));
            chk("wait_dload", dload_ext, ld_data);
            chk("wait_no_resp", 32'({resp_valid, req_ready}), 32'd0);
            if (i == lat - 1) begin
               f_ready = 1'b1;
               FPU_all_out = res;
               f_flags = fl;
               fcsr_fflags_clr = clr_rdy;
            end
            tick;
         end
         f_ready = 1'b0;
         FPU_all_out = $urandom;
         f_flags = 5'($urandom);
         fcsr_fflags_clr = 1'b0;
         ef = (ld || st) ? 5'b0 : fl;
         m_fflags = clr_rdy ? ef : (m_fflags | ef);
         exp_data = res;
         chk("resp_valid", 32'(resp_valid), 32'd1);
         chk("resp_data", resp_data, res);
         chk("resp_flags", 32'(resp_flags), 32'(ef));
         chk("resp_status", 32'({resp_illegal, resp_timeout}), 32'd0);
         chk("fflags", 32'(fcsr_fflags), 32'(m_fflags));
         chk("resp_cmd_idle", 32'({f_funct_7, f_LW, f_SW, frm_in}), 32'd0);
         chk("resp_dload_idle", dload_ext, 32'h0);
      end
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("hold_valid", 32'({resp_valid, req_ready}), 32'b10);
         chk("hold_data", resp_data, exp_data);
         chk("hold_status", 32'({resp_flags, resp_illegal, resp_timeout}), 32'({ef, bad, 1'b0}));
      end
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("done_req_ready", 32'({req_ready, resp_valid}), 32'b10);
   endtask

   initial begin
      int k;
      #1 n_rst = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp", 32'({resp_valid, resp_illegal, resp_timeout, resp_flags}), 32'd0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_fcsr", 32'({fcsr_frm, fcsr_fflags}), 32'd0);
      chk("rst_cmd", 32'({f_funct_7, f_LW, f_SW, frm_in, f_rs1}), 32'd0);
      @(negedge clk) n_rst = 1'b1;
      tick;
      // FADD, three WAIT cycles
      op(8'h00, 3'b000, 0, 0, 32'h1234, 3, 32'h40400000, 5'b00001, 0, 0, 0, 3'd0);
      // dynamic rm from frm, then illegal dynamic rm
      set_frm(3'b010);
      op(8'h04, 3'b111, 0, 0, 32'h0, 2, 32'h3F800000, 5'b00000, 0, 0, 0, 3'd0);
      set_frm(3'b101);
      op(8'h08, 3'b111, 0, 0, 32'h0, 1, 32'h0, 5'b0, 1, 0, 0, 3'd0);
      op(8'h0C, 3'b110, 0, 0, 32'h0, 1, 32'h0, 5'b0, 0, 0, 0, 3'd0);
      // FLW: flags not accumulated
      op(8'h01, 3'b000, 1, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 5'b10000, 0, 0, 0, 3'd0);
      // FSW
      op(8'h02, 3'b001, 0, 1, 32'h0, 1, 32'hCAFEF00D, 5'b01000, 0, 0, 0, 3'd0);
      // RESP held for 5 cycles
      op(8'h10, 3'b011, 0, 0, 32'h0, 1, 32'h5555AAAA, 5'b00010, 5, 0, 0, 3'd0);
      // clear and capture in the same cycle
      clr_flags;
      op(8'h00, 3'b000, 0, 0, 32'h0, 1, 32'h1, 5'b00011, 0, 0, 0, 3'd0);
      op(8'h00, 3'b000, 0, 0, 32'h0, 2, 32'h2, 5'b00100, 0, 1, 0, 3'd0);
      // frm write at acceptance does not affect that request
      set_frm(3'b001);
      op(8'h14, 3'b111, 0, 0, 32'h0, 1, 32'h7, 5'b0, 0, 0, 1, 3'b011);
      chk("frm_after_acc_wr", 32'(fcsr_frm), 32'b011);
      // randomized transactions
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 3) == 0) set_frm(3'($urandom_range(0, 7)));
         if ($urandom_range(0, 5) == 0) clr_flags;
         k = $urandom_range(0, 3);
         op(8'($urandom), 3'($urandom_range(0, 7)), k == 1, k == 2, $urandom,
            $urandom_range(1, 5), $urandom, 5'($urandom), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom));
      end
      // FPU never answers
      set_frm(3'b000);
      req_valid = 1'b1;
      req_funct_7 = 8'h20;
      req_rm = 3'b000;
      tick;
      req_valid = 1'b0;
      f_flags = 5'b11111;
      for (int i = 0; i < TO; i++) begin
         chk("to_waiting", 32'(resp_valid), 32'd0);
         tick;
      end
`ifdef FPU_TIMEOUT_EN
      chk("to_valid", 32'({resp_valid, resp_timeout}), 32'b11);
      chk("to_data", resp_data, 32'h0);
      chk("to_flags", 32'({resp_flags, resp_illegal}), 32'd0);
      chk("to_fflags", 32'(fcsr_fflags), 32'(m_fflags));
`else
      chk("no_to_valid", 32'({resp_valid, resp_timeout}), 32'b00);
      chk("no_to_funct7", 32'(f_funct_7), 32'h20);
      f_ready = 1'b1;
      f_flags = 5'b0;
      FPU_all_out = 32'h0BADF00D;
      tick;
      f_ready = 1'b0;
      chk("late_valid", 32'({resp_valid, resp_timeout}), 32'b10);
      chk("late_data", resp_data, 32'h0BADF00D);
`endif
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
      chk("to_done", 32'(req_ready), 32'd1);
      // asynchronous reset in WAIT
      set_frm(3'b100);
      req_valid = 1'b1;
      req_funct_7 = 8'h5A;
      req_rm = 3'b000;
      tick;
      req_valid = 1'b0;
      tick;
      chk("pre_rst_funct7", 32'(f_funct_7), 32'h5A);
      #2 n_rst = 1'b0;
      #1;
      m_frm = 3'b0;
      m_fflags = 5'b0;
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      chk("arst_cmd", 32'({f_funct_7, f_LW, f_SW}), 32'd0);
      chk("arst_fcsr", 32'({fcsr_frm, fcsr_fflags, resp_valid}), 32'd0);
      @(negedge clk) n_rst = 1'b1;
      tick;
      chk("post_rst_idle", 32'({req_ready, resp_valid}), 32'b10);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Core-side initiator for the FPU port: accepts one decoded floating-point instruction at a time from the integer pipeline and drives the FPU command fields. It waits for `f_ready`, then returns result and exception flags to the pipeline. It also owns the architectural `frm` and sticky `fflags` state. It sits between decode/execute and the FPU, on the opposite end of the FPU port from the FPU itself.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before abort (used only with `FPU_TIMEOUT_EN`).

- `clk` in 1: clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: accept request; equals (state == IDLE).
- `req_funct_7` in 8: operation select.
- `req_rs1`, `req_rs2`, `req_rd` in 5 each: register indices.
- `req_rm` in 3: instruction rounding mode; 3'b111 = dynamic.
- `req_is_load`, `req_is_store` in 1 each: FLW / FSW; mutually exclusive.
- `req_load_data` in 32: memory data for FLW.
- `resp_valid` out 1, `resp_ready` in 1: result handshake.
- `resp_data` out 32: FPU result, or FSW store data.
- `resp_flags` out 5: NV,DZ,OF,UF,NX of this op.
- `resp_illegal` out 1: invalid rounding mode; FPU not issued.
- `resp_timeout` out 1: FPU did not respond.
- `fcsr_frm_wr` in 1, `fcsr_frm_wdata` in 3: frm write.
- `fcsr_fflags_clr` in 1: clear sticky flags.
- `fcsr_frm` out 3, `fcsr_fflags` out 5: architectural state.
- `f_rs1`, `f_rs2`, `f_rd` out 5 each, `frm_in` out 3, `f_funct_7` out 8, `f_LW` out 1, `f_SW` out 1, `dload_ext` out 32: FPU command.
- `FPU_all_out` in 32, `f_flags` in 5, `f_ready` in 1: FPU response. `f_frm_out` in 3 is unused.

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- **IDLE**
  - On `req_valid`, capture all `req_*` fields and resolve the effective rm: `req_rm`, or the current registered `fcsr_frm` when `req_rm` is 3'b111.
  - If the effective rm is 3'b101, 3'b110 or 3'b111: go to RESP with `resp_illegal`=1, `resp_data`=0, `resp_flags`=0.
  - Otherwise go to WAIT.
- **WAIT**
  - Drive the captured fields on `f_*`, `frm_in` and `dload_ext`. `f_LW`/`f_SW` are high only in WAIT.
  - Sample `f_ready` every WAIT cycle, including the first.
  - On `f_ready`, capture `FPU_all_out` and `f_flags` into `resp_data`/`resp_flags` and go to RESP.
  - For a load or store, `resp_flags` is forced to 0.
- **RESP**
  - Hold `resp_valid`=1 and all `resp_*` stable until `resp_ready`, then go to IDLE.
- In IDLE and RESP, all FPU command outputs are 0; `f_funct_7`=0 is the idle code.
- **fflags**
  - On capture of an arithmetic result: `fcsr_fflags <= fcsr_fflags | f_flags`.
  - `fcsr_fflags_clr` sets `fcsr_fflags` to 0.
  - Clear and capture in the same cycle: `fcsr_fflags <= f_flags`.
- **frm**
  - `fcsr_frm_wr` updates `fcsr_frm` next edge.
  - A write in the same cycle as acceptance does not affect that request's dynamic rm.
- Reset values: all outputs 0 except `req_ready`=1. `fcsr_frm`=0, `fcsr_fflags`=0.
- Asynchronous reset mid-operation returns to IDLE. The pending result is discarded and the FPU outputs go to 0 immediately.

## Timing
- Acceptance edge N; FPU fields valid from cycle N+1.
- `f_ready` high in cycle M ≥ N+1 gives `resp_valid` in M+1.
- Minimum accept-to-response: 2 cycles. Illegal-rm response: `resp_valid` in N+1.
- Response handshake at edge K gives `req_ready`=1 in K+1. There is no bypass, so peak throughput is 1 op / 3 cycles.
- `resp_ready` may be held high in advance; it is ignored outside RESP.

## Configuration
- `FPU_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle without `f_ready`.
  - When it reaches `TIMEOUT_CYCLES`: go to RESP with `resp_timeout`=1, `resp_data`=0, `resp_flags`=0, and no fflags update.
  - `f_ready` in the same cycle as the limit wins, giving a normal response.
- Undefined: WAIT lasts indefinitely; `resp_timeout` is tied 0 and `TIMEOUT_CYCLES` is ignored.

## Test plan
- FADD (`req_funct_7`=8'h00, rm=3'b000). FPU returns `FPU_all_out`=32'h40400000 with `f_flags`=5'b00001 after 3 WAIT cycles. Expect `resp_valid` 4 cycles after accept, `resp_data`=32'h40400000, `fcsr_fflags`=5'b00001.
- Set `fcsr_frm`=3'b010, then issue rm=3'b111. Expect `frm_in`=3'b010 throughout WAIT. Repeat with `fcsr_frm`=3'b101: expect `resp_illegal`=1 one cycle after accept and `f_funct_7` never nonzero.
- FLW with `req_load_data`=32'hDEADBEEF. Expect `f_LW`=1 and `dload_ext`=32'hDEADBEEF during WAIT. FPU flags 5'b10000 are not accumulated, and `resp_flags`=0.
- Hold `resp_ready`=0 for 5 cycles in RESP. Expect `resp_*` stable and `req_ready`=0. Then pulse `resp_ready`: `req_ready`=1 the next cycle.
- `fcsr_fflags`=5'b00011; `fcsr_fflags_clr` in the same cycle as `f_ready` with `f_flags`=5'b00100. Expect `fcsr_fflags`=5'b00100.
- With `FPU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, hold `f_ready`=0. Expect `resp_timeout`=1 and `resp_data`=0, with fflags unchanged. Separately assert `n_rst` low during WAIT: expect IDLE, `f_funct_7`=0 and `req_ready`=1 immediately.
